// File: rtl/boot_loader_ctrl.sv
// Boot loader controller: streams an image into instruction memory, then gates
// CPU reset/execution from a debounced start button and CPU decode faults.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  IDLE       | waiting for the first image byte, CPU held in reset
//  LOAD       | receiving image bytes, one write strobe per accepted byte
//  WAIT_START | image complete (or truncated), waiting for a button press
//  RUN        | CPU released and executing
//  HALT       | CPU frozen for inspection (button or invalid instruction)
module boot_loader_ctrl #(
    parameter logic [31:0] INS_START_ADDRESS = 32'h0000_0000,
    parameter int          MAX_BYTES         = 4096,
    parameter int          DEBOUNCE_CYCLES   = 4
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset_n,
    input  logic        SYS_start_button,
    input  logic        RX_valid,
    input  logic [7:0]  RX_data,
    input  logic        RX_last,
    output logic        RX_ready,
    input  logic        invalid_instruction,
    output logic        PC_to_mem_enable,
    output logic [7:0]  PC_to_mem_data,
    output logic [31:0] PC_to_mem_address,
    output logic        CPU_reset,
    output logic        execution_enable,
    output logic [2:0]  state_o,
    output logic [31:0] byte_count,
    output logic        load_error,
    output logic        halt_cause
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        WAIT_START = 3'd2,
        RUN        = 3'd3,
        HALT       = 3'd4
    } state_t;

    localparam int          DW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_RELOAD = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] LAST_SLOT = 32'(MAX_BYTES - 1);

    state_t        state;
    state_t        state_nxt;
    logic          btn_meta;
    logic          btn_sync;
    logic          btn_level;
    logic          press;
    logic [DW-1:0] deb_cnt;
    logic          accept;
    logic          at_limit;
    logic          truncate;
    logic          clear_image;

    // Down-counter restarts whenever the sample agrees with the accepted level,
    // so only DEBOUNCE_CYCLES consecutive disagreeing samples flip the level.
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
            btn_level <= 1'b0;
            press     <= 1'b0;
            deb_cnt   <= DB_RELOAD;
        end else begin
            btn_meta <= SYS_start_button;
            btn_sync <= btn_meta;
            press    <= 1'b0;
            if (btn_sync == btn_level) begin
                deb_cnt <= DB_RELOAD;
            end else if (deb_cnt == '0) begin
                btn_level <= btn_sync;
                deb_cnt   <= DB_RELOAD;
                press     <= btn_sync;
            end else begin
                deb_cnt <= deb_cnt - 1'b1;
            end
        end
    end

    assign RX_ready         = (state == IDLE) || (state == LOAD);
    assign accept           = RX_valid && RX_ready;
    assign at_limit         = (byte_count == LAST_SLOT);
    assign CPU_reset        = (state == IDLE) || (state == LOAD) || (state == WAIT_START);
    assign execution_enable = (state == RUN);
    assign state_o          = state;

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        truncate    = 1'b0;
        clear_image = 1'b0;
        case (state)
            IDLE, LOAD: begin
                if (accept) begin
                    if (RX_last) begin
                        state_nxt = WAIT_START;
                    end else if (at_limit) begin
                        state_nxt = WAIT_START;
                        truncate  = 1'b1;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            WAIT_START: begin
                if (press) state_nxt = RUN;
            end
            RUN: begin
                if (invalid_instruction || press) state_nxt = HALT;
            end
            HALT: begin
                if (press) begin
                    state_nxt   = IDLE;
                    clear_image = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            PC_to_mem_enable  <= 1'b0;
            PC_to_mem_data    <= 8'h00;
            PC_to_mem_address <= 32'h0;
            byte_count        <= 32'h0;
            load_error        <= 1'b0;
            halt_cause        <= 1'b0;
        end else begin
            PC_to_mem_enable <= accept;
            if (accept) begin
                PC_to_mem_data    <= RX_data;
                PC_to_mem_address <= INS_START_ADDRESS + byte_count;
            end
            if (clear_image) begin
                byte_count <= 32'h0;
            end else if (accept) begin
                byte_count <= byte_count + 32'h1;
            end
            if (clear_image) begin
                load_error <= 1'b0;
            end else if (truncate) begin
                load_error <= 1'b1;
            end
            // Fault wins over a simultaneous press.
            if ((state == RUN) && (state_nxt == HALT)) begin
                halt_cause <= invalid_instruction;
            end
        end
    end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl: a default instance for the full flow and
// a MAX_BYTES=4 instance at base 0x100 for image truncation.
module tb_boot_loader_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn, rx_valid, rx_last, invalid;
    logic [7:0]  rx_data;
    logic        rx_ready, mem_en, cpu_reset, exe_en, load_error, halt_cause;
    logic [7:0]  mem_data;
    logic [31:0] mem_addr, byte_count;
    logic [2:0]  state;

    logic        b_btn, b_valid, b_last, b_invalid;
    logic [7:0]  b_data;
    logic        b_ready, b_en, b_cpu_reset, b_exe_en, b_load_error, b_halt_cause;
    logic [7:0]  b_mem_data;
    logic [31:0] b_addr, b_count;
    logic [2:0]  b_state;

    int n_tests = 0;
    int n_fail  = 0;
    int strobes;

    always #5 clk = ~clk;

    boot_loader_ctrl dut (
        .SYS_clk(clk), .SYS_reset_n(rst_n), .SYS_start_button(btn),
        .RX_valid(rx_valid), .RX_data(rx_data), .RX_last(rx_last), .RX_ready(rx_ready),
        .invalid_instruction(invalid), .PC_to_mem_enable(mem_en), .PC_to_mem_data(mem_data),
        .PC_to_mem_address(mem_addr), .CPU_reset(cpu_reset), .execution_enable(exe_en),
        .state_o(state), .byte_count(byte_count), .load_error(load_error), .halt_cause(halt_cause)
    );

    boot_loader_ctrl #(.INS_START_ADDRESS(32'h0000_0100), .MAX_BYTES(4), .DEBOUNCE_CYCLES(4)) dut_b (
        .SYS_clk(clk), .SYS_reset_n(rst_n), .SYS_start_button(b_btn),
        .RX_valid(b_valid), .RX_data(b_data), .RX_last(b_last), .RX_ready(b_ready),
        .invalid_instruction(b_invalid), .PC_to_mem_enable(b_en), .PC_to_mem_data(b_mem_data),
        .PC_to_mem_address(b_addr), .CPU_reset(b_cpu_reset), .execution_enable(b_exe_en),
        .state_o(b_state), .byte_count(b_count), .load_error(b_load_error), .halt_cause(b_halt_cause)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_button(input int hold);
        btn = 1'b1;
        tick(hold);
        btn = 1'b0;
        tick(10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; btn = 1'b0; rx_valid = 1'b0; rx_last = 1'b0; rx_data = 8'h00; invalid = 1'b0;
        b_btn = 1'b0; b_valid = 1'b0; b_last = 1'b0; b_data = 8'h00; b_invalid = 1'b0;
        tick(2);
        check_val("rst_state", state, 0);
        check_val("rst_cpu_reset", cpu_reset, 1);
        check_val("rst_exe", exe_en, 0);
        check_val("rst_count", byte_count, 0);
        check_val("rst_mem_en", mem_en, 0);
        check_val("rst_addr", mem_addr, 0);
        check_val("rst_data", mem_data, 0);
        check_val("rst_err", load_error, 0);
        check_val("rst_cause", halt_cause, 0);
        rst_n = 1'b1;
        tick(1);
        check_val("rst_ready", rx_ready, 1);

        // truncation at MAX_BYTES=4: six bytes offered, four written
        strobes = 0;
        b_valid = 1'b1; b_data = 8'hA0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            if (b_en) strobes++;
            if (k == 3) begin
                check_val("trunc_ready", b_ready, 0);
                check_val("trunc_err", b_load_error, 1);
                check_val("trunc_addr", b_addr, 32'h103);
                check_val("trunc_data", b_mem_data, 8'hA3);
            end
            b_data  = 8'hA1 + 8'(k);
            b_valid = (k < 5);
        end
        check_val("trunc_strobes", strobes, 4);
        check_val("trunc_count", b_count, 4);
        check_val("trunc_state", b_state, 2);

        // eight bytes back-to-back, last on 0x88
        rx_valid = 1'b1; rx_data = 8'h11; rx_last = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check_val("load_en", mem_en, 1);
            check_val("load_addr", mem_addr, 32'(k));
            check_val("load_data", mem_data, 8'h11 * 8'(k + 1));
            if (k < 7) begin
                rx_data = 8'h11 * 8'(k + 2);
                rx_last = (k == 6);
            end else begin
                rx_valid = 1'b0; rx_last = 1'b0;
            end
        end
        check_val("load_state", state, 2);
        check_val("load_count", byte_count, 8);
        check_val("load_ready", rx_ready, 0);
        rx_valid = 1'b1; rx_data = 8'hEE;
        tick(1);
        check_val("wait_ignore_en", mem_en, 0);
        tick(1);
        check_val("wait_ignore_cnt", byte_count, 8);
        rx_valid = 1'b0;

        btn = 1'b1;
        tick(2);
        btn = 1'b0;
        tick(10);
        check_val("glitch_state", state, 2);

        btn = 1'b1;
        tick(10);
        check_val("run_state", state, 3);
        check_val("run_cpu_reset", cpu_reset, 0);
        check_val("run_exe", exe_en, 1);
        btn = 1'b0;
        tick(10);
        check_val("run_single", state, 3);

        // press pulse lands on the 7th edge; invalid_instruction joins it there
        btn = 1'b1;
        tick(6);
        check_val("pre_halt_state", state, 3);
        invalid = 1'b1;
        tick(1);
        invalid = 1'b0; btn = 1'b0;
        check_val("halt_state", state, 4);
        check_val("halt_cause_inv", halt_cause, 1);
        check_val("halt_exe", exe_en, 0);
        check_val("halt_cpu_reset", cpu_reset, 0);
        tick(10);
        push_button(10);
        check_val("clear_state", state, 0);
        check_val("clear_cpu_reset", cpu_reset, 1);
        check_val("clear_count", byte_count, 0);
        check_val("clear_err", load_error, 0);
        check_val("clear_ready", rx_ready, 1);
        push_button(10);
        check_val("idle_press", state, 0);

        rx_valid = 1'b1; rx_data = 8'h5A; rx_last = 1'b1;
        tick(1);
        rx_valid = 1'b0; rx_last = 1'b0;
        check_val("one_addr", mem_addr, 0);
        check_val("one_data", mem_data, 8'h5A);
        check_val("one_state", state, 2);
        push_button(10);
        check_val("one_run", state, 3);
        push_button(10);
        check_val("btn_halt_state", state, 4);
        check_val("btn_halt_cause", halt_cause, 0);
        push_button(10);

        // reset after 3 bytes while a 4th is on the bus
        rx_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rx_data = 8'h11 * 8'(k + 1);
            tick(1);
        end
        check_val("mid_count", byte_count, 3);
        rx_data = 8'h44;
        rst_n = 1'b0;
        tick(1);
        check_val("abort_en", mem_en, 0);
        check_val("abort_state", state, 0);
        check_val("abort_count", byte_count, 0);
        check_val("abort_addr", mem_addr, 0);
        check_val("abort_data", mem_data, 0);
        check_val("abort_cpu_reset", cpu_reset, 1);
        rx_valid = 1'b0;
        rst_n = 1'b1;
        tick(1);
        check_val("abort_ready", rx_ready, 1);
        rx_valid = 1'b1; rx_data = 8'h99;
        tick(1);
        rx_valid = 1'b0;
        check_val("restart_en", mem_en, 1);
        check_val("restart_addr", mem_addr, 0);
        check_val("restart_data", mem_data, 8'h99);
        check_val("restart_count", byte_count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/boot_loader_ctrl.md
BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 SHALL have parameter INS_START_ADDRESS, default 32'h0000_0000, instruction-memory base address for the first image byte.
REQ-002 SHALL have parameter MAX_BYTES, default 4096, image size limit in bytes.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples before a button level change is accepted.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: SYS_clk  in  1  system clock, rising edge.
REQ-005 SYS_reset_n  in  1  asynchronous active-low reset.
REQ-006 SYS_start_button  in  1  raw, asynchronous push button.
REQ-007 RX_valid  in  1  image byte valid.
REQ-008 RX_data  in  8  image byte.
REQ-009 RX_last  in  1  qualifies the final image byte.
REQ-010 RX_ready  out  1  byte accept; a transfer occurs on an edge where RX_valid and RX_ready are both 1.
REQ-011 invalid_instruction  in  1  CPU decode fault.
REQ-012 PC_to_mem_enable  out  1  one-cycle byte write strobe to instruction memory.
REQ-013 PC_to_mem_data  out  8  byte to write.
REQ-014 PC_to_mem_address  out  32  byte write address.
REQ-015 CPU_reset  out  1  active-high synchronous reset to CPU core.
REQ-016 execution_enable  out  1  CPU may commit state.
REQ-017 state_o  out  3  current state code.
REQ-018 byte_count  out  32  bytes loaded in current image.
REQ-019 load_error  out  1  sticky: image truncated at MAX_BYTES.
REQ-020 halt_cause  out  1  0 = stopped by button, 1 = invalid_instruction.

Function
REQ-021 SHALL implement states IDLE=0, LOAD=1, WAIT_START=2, RUN=3, HALT=4; all outputs registered or decoded from the state register only (Moore).
REQ-022 SHALL synchronize SYS_start_button through two flops, debounce it over DEBOUNCE_CYCLES, and produce a one-cycle press pulse on each debounced 0->1 transition only.
REQ-023 RX_ready SHALL be 1 exactly in IDLE and LOAD.
REQ-024 Each accepted byte SHALL drive PC_to_mem_enable=1 for exactly the following cycle, with PC_to_mem_data = byte and PC_to_mem_address = INS_START_ADDRESS + byte_count value before increment; byte_count increments on the accepting edge.
REQ-025 IDLE: accepted byte -> LOAD (or -> WAIT_START if RX_last=1); press ignored while byte_count=0.
REQ-026 LOAD: accepted byte with RX_last=1 -> WAIT_START; sustained throughput one byte per cycle; press ignored.
REQ-027 LOAD/IDLE: accepted byte making byte_count = MAX_BYTES without RX_last -> WAIT_START with load_error=1; no further bytes are accepted.
REQ-028 WAIT_START: press -> RUN; at that edge CPU_reset falls 1->0 and execution_enable rises 0->1.
REQ-029 RUN: invalid_instruction=1 at an edge -> HALT, halt_cause=1; press -> HALT, halt_cause=0; both at the same edge -> HALT, halt_cause=1.
REQ-030 HALT: execution_enable=0, CPU_reset=0 (CPU state held for inspection); press -> IDLE with byte_count=0, load_error=0, CPU_reset=1.
REQ-031 CPU_reset SHALL be 1 in IDLE, LOAD, WAIT_START; 0 in RUN, HALT.
REQ-032 RX_valid in WAIT_START, RUN, HALT SHALL be ignored (no write, no count change).

Reset
REQ-033 SYS_reset_n=0 SHALL immediately force: state IDLE, RX_ready=1 on release, PC_to_mem_enable=0, PC_to_mem_data=0, PC_to_mem_address=0, CPU_reset=1, execution_enable=0, byte_count=0, load_error=0, halt_cause=0, debounce state cleared.
REQ-034 Reset asserted mid-LOAD or mid-RUN SHALL abort with no further memory write strobes after assertion.

Verification
REQ-035 Load 8 bytes 0x11..0x88 back-to-back, last on 0x88 -> 8 strobes at addresses 0x0..0x7 in consecutive cycles, byte_count=8, state WAIT_START.
REQ-036 WAIT_START, button held high 10 cycles (DEBOUNCE_CYCLES=4) -> exactly one transition to RUN, CPU_reset=0, execution_enable=1.
REQ-037 RUN, invalid_instruction and press same edge -> HALT, halt_cause=1, execution_enable=0; next press -> IDLE, CPU_reset=1, byte_count=0.
REQ-038 MAX_BYTES=4, stream 6 bytes without RX_last -> 4 strobes, load_error=1, RX_ready=0 after 4th byte.
REQ-039 Button glitch of 2 cycles in WAIT_START -> no state change; press in IDLE with byte_count=0 -> no state change.
REQ-040 SYS_reset_n pulsed low after 3 of 8 bytes -> all outputs at reset values, next byte written to INS_START_ADDRESS.
